// File: rtl/modexp_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : modexp_arbiter_if
// Brief    : Bus bundle between two modexp requesters, the arbiter and the
//            shared modular-exponentiation engine.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface modexp_arbiter_if #(
   parameter int DATA_W  = 512,
   parameter int e_WIDTH = 3
);
   localparam int c_YW = DATA_W + e_WIDTH + 1;

   // requester side
   logic              req0,   req1;
   logic [DATA_W-1:0] x0,     x1;
   logic [DATA_W-1:0] m0,     m1;
   logic [c_YW-1:0]   y0,     y1;
   logic [9:0]        ysize0, ysize1;
   logic              gnt0,   gnt1;
   logic              done0,  done1;
   logic [DATA_W-1:0] result;
   logic              err;
   logic              busy;

   // engine side
   logic              eng_rst;
   logic              eng_start;
   logic [DATA_W-1:0] eng_x;
   logic [DATA_W-1:0] eng_m;
   logic [c_YW-1:0]   eng_y;
   logic [9:0]        eng_y_size;
   logic              eng_ready;
   logic [DATA_W-1:0] eng_out;

   // arbiter view
   modport slave (
      input  req0, req1, x0, x1, m0, m1, y0, y1, ysize0, ysize1,
      input  eng_ready, eng_out,
      output gnt0, gnt1, done0, done1, result, err, busy,
      output eng_rst, eng_start, eng_x, eng_m, eng_y, eng_y_size
   );

   // requester/engine view
   modport master (
      output req0, req1, x0, x1, m0, m1, y0, y1, ysize0, ysize1,
      output eng_ready, eng_out,
      input  gnt0, gnt1, done0, done1, result, err, busy,
      input  eng_rst, eng_start, eng_x, eng_m, eng_y, eng_y_size
   );
endinterface
`default_nettype wire

// File: rtl/modexp_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : modexp_arbiter
// Brief    : Two-requester round-robin arbiter in front of one modexp engine.
//            IDLE -> ARM -> START -> RUN -> DONE -> IDLE.
//            Optional RUN watchdog enabled by macro MODEXP_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module modexp_arbiter #(
   parameter int DATA_W         = 512,
   parameter int e_WIDTH        = 3,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  wire logic         clk,
   input  wire logic         rst,   // synchronous, active-low
   modexp_arbiter_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARM   = 3'd1,
      S_START = 3'd2,
      S_RUN   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t            state_q;
   logic              gnt0_q, gnt1_q;
   logic              done0_q, done1_q;
   logic              err_q;
   logic              start_q;
   logic              eng_rst_q;
   logic              busy_q;
   logic              last_q;      // 1 = requester 1 was granted last
   logic [DATA_W-1:0] result_q;
   logic              pick1_d;     // arbitration result for this IDLE cycle

`ifdef MODEXP_ARB_TIMEOUT_EN
   localparam int              c_CW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_CW-1:0] c_TO_LAST = c_CW'(TIMEOUT_CYCLES - 1);
   logic [c_CW-1:0]            cnt_q;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

   // Round-robin pick: a lone request wins; on contention the one not served last wins.
   always_comb begin
      pick1_d = 1'b0;
      if (bus.req0 && bus.req1) pick1_d = ~last_q;
      else                      pick1_d = bus.req1;
   end

   // Main controller: state, grants and all status pulses are registered here.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         done0_q   <= 1'b0;
         done1_q   <= 1'b0;
         err_q     <= 1'b0;
         start_q   <= 1'b0;
         eng_rst_q <= 1'b0;
         busy_q    <= 1'b0;
         last_q    <= 1'b1;
         result_q  <= '0;
`ifdef MODEXP_ARB_TIMEOUT_EN
         cnt_q     <= '0;
`endif
      end else begin
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         err_q   <= 1'b0;
         start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.req0 || bus.req1) begin
                  state_q   <= S_ARM;
                  gnt0_q    <= ~pick1_d;
                  gnt1_q    <= pick1_d;
                  last_q    <= pick1_d;
                  eng_rst_q <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            S_ARM: begin
               state_q <= S_START;
               start_q <= 1'b1;
            end
            S_START: begin
               state_q <= S_RUN;
`ifdef MODEXP_ARB_TIMEOUT_EN
               cnt_q   <= '0;
`endif
            end
            S_RUN: begin
               if (bus.eng_ready) begin
                  state_q  <= S_DONE;
                  result_q <= bus.eng_out;
                  done0_q  <= gnt0_q;
                  done1_q  <= gnt1_q;
               end
`ifdef MODEXP_ARB_TIMEOUT_EN
               else if (cnt_q == c_TO_LAST) begin
                  // watchdog expired: finish with a zero result and flag it
                  state_q  <= S_DONE;
                  result_q <= '0;
                  done0_q  <= gnt0_q;
                  done1_q  <= gnt1_q;
                  err_q    <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + c_CW'(1);
               end
`endif
            end
            S_DONE: begin
               state_q   <= S_IDLE;
               gnt0_q    <= 1'b0;
               gnt1_q    <= 1'b0;
               eng_rst_q <= 1'b0;
               busy_q    <= 1'b0;
            end
            default: begin
               state_q   <= S_IDLE;
               gnt0_q    <= 1'b0;
               gnt1_q    <= 1'b0;
               eng_rst_q <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.gnt0      = gnt0_q;
   assign bus.gnt1      = gnt1_q;
   assign bus.done0     = done0_q;
   assign bus.done1     = done1_q;
   assign bus.err       = err_q;
   assign bus.busy      = busy_q;
   assign bus.result    = result_q;
   assign bus.eng_rst   = eng_rst_q;
   assign bus.eng_start = start_q;

   // Operands follow the owner combinationally; zero when nobody holds the engine.
   assign bus.eng_x      = gnt1_q ? bus.x1     : (gnt0_q ? bus.x0     : '0);
   assign bus.eng_m      = gnt1_q ? bus.m1     : (gnt0_q ? bus.m0     : '0);
   assign bus.eng_y      = gnt1_q ? bus.y1     : (gnt0_q ? bus.y0     : '0);
   assign bus.eng_y_size = gnt1_q ? bus.ysize1 : (gnt0_q ? bus.ysize0 : '0);

endmodule
`default_nettype wire

// File: doc/modexp_arbiter.md
MODEXP_ARBITER -- requirements
Module: modexp_arbiter

Interface
REQ-001 Parameter DATA_W, default 512: width of x, m and result operands.
REQ-002 Parameter e_WIDTH, default 3: exponent extension width; y is DATA_W+e_WIDTH+1 bits wide.
REQ-003 Parameter TIMEOUT_CYCLES, default 1048576: RUN-state watchdog limit; used only when MODEXP_ARB_TIMEOUT_EN is defined.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 reqN  in  1  level request from requester N (N=0 keygen, N=1 decrypt).
REQ-007 xN, mN  in  DATA_W  base and modulus from requester N.
REQ-008 yN  in  DATA_W+e_WIDTH+1  exponent from requester N.
REQ-009 ysizeN  in  10  exponent bit count from requester N.
REQ-010 gntN  out  1  requester N owns the engine.
REQ-011 doneN  out  1  one-cycle completion pulse to requester N.
REQ-012 result  out  DATA_W  latched engine output of the last completed operation.
REQ-013 err  out  1  one-cycle pulse concurrent with doneN when the operation timed out.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 eng_rst, eng_start  out  1  engine reset (active-low) and start pulse.
REQ-016 eng_x, eng_m  out  DATA_W; eng_y  out  DATA_W+e_WIDTH+1; eng_y_size  out  10  muxed operands.
REQ-017 eng_ready  in  1; eng_out  in  DATA_W  engine completion flag and result.

Function
REQ-018 States: IDLE, ARM, START, RUN, DONE; IDLE->ARM when any req high, ARM->START, START->RUN, RUN->DONE on eng_ready, DONE->IDLE unconditionally.
REQ-019 Arbitration in IDLE: single request wins; both high -> requester not granted last wins; after reset requester 0 has priority.
REQ-020 gntN is high from ARM through DONE inclusive for the winner only; at most one gnt high at any cycle.
REQ-021 eng_rst is low in IDLE and high in ARM, START, RUN, DONE.
REQ-022 eng_start is high exactly in START (one cycle).
REQ-023 eng_x/y/y_size/m equal the granted requester's inputs while gnt is high and zero in IDLE.
REQ-024 eng_ready is ignored outside RUN; eng_ready already high on RUN entry completes in one cycle.
REQ-025 In DONE: result <= eng_out (captured on the RUN->DONE edge), doneN high for one cycle, err low unless timeout.
REQ-026 Latency: req sampled in IDLE at cycle 0 -> gnt at cycle 1, eng_start at cycle 2, done one cycle after eng_ready seen in RUN.
REQ-027 Requester dropping req mid-operation does not abort; the operation completes and doneN still pulses.
REQ-028 Requester holds req high in the cycle after done -> eligible again in IDLE under REQ-019 (no back-to-back starvation of the other).
REQ-029 Operand inputs are sampled combinationally; requesters hold them stable while gnt is high.

Reset
REQ-030 On rst low at a clock edge: state IDLE, all gnt/done/err/eng_start low, eng_rst low, busy low, result zero, last-grant = 1 (so requester 0 wins first).
REQ-031 rst low mid-operation aborts immediately; no done pulse is produced for the aborted operation.

Configuration
REQ-032 Macro MODEXP_ARB_TIMEOUT_EN defined: a counter clears on RUN entry, increments each RUN cycle; reaching TIMEOUT_CYCLES without eng_ready forces DONE with result zero and err pulsed with doneN.
REQ-033 Macro undefined: no counter is built, RUN waits indefinitely, err is tied low.

Verification
REQ-034 rst low 2 cycles then req0=1, eng_ready at RUN cycle 5, eng_out=0x1234 -> gnt0 cycle 1, eng_start cycle 2, done0 one cycle, result=0x1234.
REQ-035 req0=req1=1 held continuously -> grants alternate 0,1,0,1 over four operations; never both gnt high.
REQ-036 req1 only, x1=7, y1=3, m1=11 -> eng_x=7, eng_y=3, eng_m=11 while gnt1; eng_x=0 in IDLE; done1 only.
REQ-037 rst low during RUN -> next cycle IDLE, eng_rst low, gnt low, no done pulse; later req0 served normally.
REQ-038 With MODEXP_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, eng_ready never asserted -> done0 and err pulse together after 16 RUN cycles, result=0.
REQ-039 eng_ready held high during IDLE/ARM/START -> ignored; RUN lasts exactly one cycle then DONE.
